palette_lookup_arbiter: RTL and testbench

- Shared 16-entry x 12-bit sprite palette (RGB444) serving up to NUM_REQ sprite renderers (player heads, bodies, food, background) that request colour lookups concurrently.
- Round-robin arbitration; one lookup per cycle; registered response with downstream back-pressure.
- CPU/game-logic port rewrites palette entries at runtime (player recolour, flash effects).
- Sits between the sprite ROM index outputs and the VGA colour mapper.

---
 rtl/palette_lookup_arbiter.sv | 149 ++++++++++++++
 tb/tb_palette_lookup_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
//   Shared 16 x 12-bit (RGB444) sprite palette serving NUM_REQ renderers.
//   Requests are arbitrated round-robin, one lookup is accepted per cycle and
//   the colour comes back through a single registered response stage that
//   honours downstream back-pressure. A CPU port rewrites entries at runtime.
//
// Ports
//   Clk, Reset_n       clock, asynchronous active-low reset
//   req, req_idx       per-requester request and 4-bit palette index
//   gnt                one-hot combinational grant (request accepted this cycle)
//   rsp_valid/ready    response handshake
//   rsp_id             requester owning the response
//   rsp_rgb            looked-up colour {r,g,b}
//   rsp_transparent    looked-up index equals TRANSPARENT_IDX
//   cfg_we/addr/data   palette entry write port
module palette_lookup_arbiter #(
  parameter int unsigned   NUM_REQ         = 4,
  parameter int unsigned   TRANSPARENT_IDX = 0,
  parameter logic [191:0]  DEFAULT_PALETTE =
    192'hF0F_2C7_F8A_B5E_E42_8AA_1C6_695_DDC_3D8_2B6_7DA_1D6_C78_F48_4A8,
  localparam int unsigned  IDW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_idx,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [11:0]            rsp_rgb,
  output logic                   rsp_transparent,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [11:0]            cfg_data
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [3:0]   TIDX   = 4'(TRANSPARENT_IDX);

  logic [11:0]    pal_q [16];
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]    rsp_rgb_q, rsp_rgb_d;
  logic           rsp_transp_q, rsp_transp_d;

  logic           found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;
  logic [3:0]     sel_idx;
  logic           accept;

  // Round-robin scan starting at rr_ptr; the sum is one bit wider so the
  // wrap works for non-power-of-two requester counts.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum >= NREQ_W) cand_sum = cand_sum - NREQ_W;
      cand = cand_sum[IDW-1:0];
      if (!found && req[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == IDW'(i)) sel_idx = req_idx[4*i +: 4];
    end
  end

  // Reset_n gates the accept so no grant escapes while reset is held.
  assign accept = Reset_n && found && (!rsp_valid_q || rsp_ready);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      gnt[i] = accept && (grant_id == IDW'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Response stage: load on accept, drop when consumed, otherwise hold.
  // The colour is captured here, so later palette writes cannot disturb a
  // stalled response.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_rgb_d    = rsp_rgb_q;
    rsp_transp_d = rsp_transp_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_rgb_d    = pal_q[sel_idx];
      rsp_transp_d = (sel_idx == TIDX);
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_rgb_q    <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_rgb_q    <= rsp_rgb_d;
      rsp_transp_q <= rsp_transp_d;
    end
  end

  // Palette read above uses the pre-edge contents, so a same-cycle write to
  // the granted entry returns the old colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int e = 0; e < 16; e++) begin
        pal_q[e] <= DEFAULT_PALETTE[191-12*e -: 12];
      end
    end else if (cfg_we) begin
      pal_q[cfg_addr] <= cfg_data;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_rgb         = rsp_rgb_q;
  assign rsp_transparent = rsp_transp_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Testbench for palette_lookup_arbiter: directed scenarios plus a short
// random phase, checked against a scoreboard of expected responses.
module tb_palette_lookup_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [15:0] req_idx;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_rgb;
  logic        rsp_transparent;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;

  palette_lookup_arbiter dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .req             (req),
    .req_idx         (req_idx),
    .gnt             (gnt),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_rgb         (rsp_rgb),
    .rsp_transparent (rsp_transparent),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] rgb;
    logic        tr;
  } exp_t;

  localparam logic [11:0] DEF_PAL [16] = '{
    12'hF0F, 12'h2C7, 12'hF8A, 12'hB5E, 12'hE42, 12'h8AA, 12'h1C6, 12'h695,
    12'hDDC, 12'h3D8, 12'h2B6, 12'h7DA, 12'h1D6, 12'hC78, 12'hF48, 12'h4A8};

  exp_t        sb_q[$];
  logic [11:0] mpal [16];
  int          mptr;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    mptr = 0;
    for (int e = 0; e < 16; e++) mpal[e] = DEF_PAL[e];
  endtask

  task automatic idle_inputs();
    req       = '0;
    req_idx   = '0;
    rsp_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
  endtask

  // One cycle: sample at the falling edge, check grant and current response,
  // update the scoreboard, then advance past the rising edge.
  task automatic step();
    logic [3:0] eg;
    logic       acc;
    int         gi;
    logic [3:0] idx;
    exp_t       e;
    @(negedge Clk);
    eg = '0;
    gi = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (mptr + k) % 4;
      if (eg == 4'b0 && req[j]) begin
        eg = 4'b1 << j;
        gi = j;
      end
    end
    acc = (req != 4'b0) && (sb_q.size() == 0 || rsp_ready);
    if (!acc) eg = '0;
    chk("gnt", 32'(gnt), 32'(eg));
    if (sb_q.size() > 0) begin
      e = sb_q[0];
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
      chk("rsp_transparent", 32'(rsp_transparent), 32'(e.tr));
      if (rsp_ready) void'(sb_q.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
    if (acc) begin
      idx  = req_idx[4*gi +: 4];
      e.id  = 2'(gi);
      e.rgb = mpal[idx];
      e.tr  = (idx == 4'd0);
      sb_q.push_back(e);
      mptr = (gi + 1) % 4;
    end
    if (cfg_we) mpal[cfg_addr] = cfg_data;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset values
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_rgb", 32'(rsp_rgb), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);

    // Single lookup: requester 1, index 4
    req = 4'b0010; req_idx = 16'h0040;
    step();
    idle_inputs();
    step();

    // All four requesting index 0 for 8 cycles
    do_reset();
    req = 4'b1111; req_idx = 16'h0000;
    repeat (8) step();
    idle_inputs();
    step();

    // Stall: requester 2 idx 9 accepted, then ready low with requester 3
    // pending; entry 9 rewritten during the stall must not leak out
    req = 4'b0100; req_idx = 16'h0900;
    step();
    req = 4'b1000; req_idx = 16'h3000; rsp_ready = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 12'hABC;
    step();
    cfg_we = 1'b0;
    repeat (2) step();
    rsp_ready = 1'b1;
    step();
    idle_inputs();
    step();

    // Read-before-write on entry 7, then read the new value
    req = 4'b0001; req_idx = 16'h0007;
    cfg_we = 1'b1; cfg_addr = 4'd7; cfg_data = 12'h123;
    step();
    cfg_we = 1'b0;
    step();
    idle_inputs();
    step();

    // Pointer wrap: grant 2, then 3 and 0 from req=1001, then check pointer=1
    req = 4'b0100; req_idx = 16'h0500;
    step();
    req = 4'b1001; req_idx = 16'h2001;
    repeat (2) step();
    req = 4'b1111; req_idx = 16'hFEDC;
    step();
    idle_inputs();
    step();

    // Transparent entry rewritten: flag follows index, colour follows write
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'h456;
    step();
    cfg_we = 1'b0;
    req = 4'b0010; req_idx = 16'h0000;
    step();
    idle_inputs();
    step();

    // Reset mid-operation with a stalled response after entry 5 rewrite
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 12'hAAA;
    step();
    cfg_we = 1'b0;
    req = 4'b0001; req_idx = 16'h0005;
    step();
    req = 4'b0001; rsp_ready = 1'b0;
    step();
    Reset_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_gnt", 32'(gnt), 32'd0);
    model_reset();
    @(posedge Clk);
    #1;
    chk("midreset_gnt_held", 32'(gnt), 32'd0);
    Reset_n = 1'b1;
    rsp_ready = 1'b1; req = 4'b0001; req_idx = 16'h0005;
    step();
    idle_inputs();
    step();

    // Random traffic with back-pressure, withdrawals and palette writes
    for (int n = 0; n < 80; n++) begin
      req       = 4'($urandom_range(0, 15));
      req_idx   = 16'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 4'($urandom());
      cfg_data  = 12'($urandom());
      step();
    end
    idle_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
